datapath_pack_fifo: RTL and testbench
=====================================

# datapath_pack_fifo

Parametrised width-packing FIFO for the driver datapath. It assembles PACK consecutive IN_W-bit input beats into one OUT_W-bit entry and stores entries in a DEPTH-entry circular buffer. Entries are drained at a paced rate of at most one every RD_DIV cycles. It sits between the host-side 128-bit write stream and the slower output-side consumer, and adds over its predecessor:
- a generic pack ratio;
- an exact occupancy count;
- a programmable threshold;
- flush;
- explicitly cleared error flags.

## Interface
Parameters:
- IN_W, 128, input beat width.
- PACK, 2, input beats per entry (2..8).
- OUT_W, 192, entry width; IN_W*(PACK-1) < OUT_W <= IN_W*PACK.
- DEPTH, 1024, entries; power of two, >= 4.
- AW, 10, log2(DEPTH).
- RD_DIV, 30, read pacing period in clk cycles (1..64).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr  in  1  input beat valid.
- data_in  in  IN_W  input beat.
- in_ready  out  1  beat accepted this cycle when wr=1.
- rd  in  1  consumer requests an entry.
- rd_strobe  out  1  read fired this cycle (one-cycle pulse).
- data_out  out  OUT_W  last entry read.
- data_count  out  AW+1  committed entries, 0..DEPTH.
- thresh_level  in  AW+1  threshold compare level.
- threshold  out  1  data_count >= thresh_level.
- full  out  1  data_count == DEPTH.
- empty  out  1  data_count == 0.
- flush  in  1  discard all contents.
- clr_err  in  1  clear sticky error flags.
- overflow  out  1  sticky: write beat rejected.
- underflow  out  1  sticky: paced read attempted while empty.

## Operation
- Beat counter bcnt cycles 0..PACK-1.
- Accepted beat k is held in an assembly register; entry bits are the PACK beats concatenated, beat 0 in the MSBs, truncated to the low OUT_W bits. The high IN_W*PACK-OUT_W bits of the last beat are discarded.
  - Default config: beat0 -> [191:64]; beat1[63:0] -> [63:0].
- in_ready = !full || bcnt != 0. A started entry always completes, because reads can only free space.
- Commit: on the accepted beat with bcnt == PACK-1, the full entry is written to mem[wptr] and wptr increments. Partial entries are not counted.
- Pointers are AW+1 bits and wrap naturally. data_count = wptr - rptr as an AW+1-bit difference.
- Pace counter pc counts 0..RD_DIV-1 free-running; tick = (pc == RD_DIV-1).
- rd_strobe = rd && tick && !empty.
  - On rd_strobe: data_out <= mem[rptr], rptr increments.
  - Otherwise data_out holds its value.
- Commit and read in the same cycle: data_count unchanged.
- overflow is set when wr && !in_ready. underflow is set when rd && tick && empty.
- Both flags clear only on clr_err. If set and clear occur in the same cycle, set wins.
- flush (synchronous) zeroes wptr, rptr and bcnt, and drops any partial entry. Flag, data_out and pc are unaffected. flush overrides a same-cycle write or read; neither takes effect.

## Timing
- Reset values: all pointers, bcnt and pc = 0; data_out = 0; data_count = 0; empty = 1; full, threshold (if thresh_level > 0), overflow, underflow and rd_strobe = 0; in_ready = 1.
- Asserting rst mid-entry or mid-read aborts the operation. No partial state survives.
- Write latency: the commit cycle's edge updates data_count. empty deasserts the next cycle, and the entry is readable on the following tick.
- Read latency (registered mode): data_out is valid the cycle after rd_strobe.
- full, empty, threshold and in_ready are combinational from the registered pointers and bcnt.
- First tick after reset occurs at cycle RD_DIV-1. Subsequent ticks occur every RD_DIV cycles. RD_DIV = 1 means a tick every cycle.
- Sustained throughput: one entry per max(PACK, RD_DIV) cycles.

## Configuration
- PACK_FIFO_FWFT_EN defined: first-word-fall-through.
  - data_out = mem[rptr] combinationally whenever !empty.
  - rd_strobe pops the entry.
  - While empty, data_out holds the last popped value.
- Undefined: registered output as described above, with one-cycle read latency.

## Test plan
- Default params, DEPTH=16, RD_DIV=4. Write beats A=0x0123..(128b) and B with B[63:0]=0xDEADBEEF_CAFEF00D; hold rd=1 -> one rd_strobe at the next tick; the following cycle data_out = {A, 0xDEADBEEF_CAFEF00D}; data_count goes 1 -> 0.
- Write 32 beats with rd=0 -> full=1 and data_count=16. A 33rd beat with wr=1 -> in_ready=0 and overflow=1. Pulse clr_err -> overflow=0.
- Fill 16 entries, then stream 1 entry in / 1 out for 40 entries -> wptr and rptr wrap twice, output order preserved, data_count constant.
- Empty FIFO, rd=1 for 8 cycles -> no rd_strobe; underflow=1 after the first tick. A same-cycle underflow and clr_err -> underflow remains 1.
- Write 1 beat, then flush -> bcnt=0. The next two beats form a new entry; no data from the pre-flush beat appears.
- thresh_level=5: commit entry 5 -> threshold=1 the same cycle data_count=5; one read -> threshold=0.

Source files
------------

// File: rtl/datapath_pack_fifo_if.sv
// rtl/datapath_pack_fifo_if.sv - write-beat and paced-read handshake bundle for datapath_pack_fifo
interface datapath_pack_fifo_if #(
  parameter int IN_W  = 128,
  parameter int OUT_W = 192
);
  logic             wr;
  logic [IN_W-1:0]  data_in;
  logic             in_ready;
  logic             rd;
  logic             rd_strobe;
  logic [OUT_W-1:0] data_out;

  modport master (
    output wr, data_in, rd,
    input  in_ready, rd_strobe, data_out
  );

  modport slave (
    input  wr, data_in, rd,
    output in_ready, rd_strobe, data_out
  );
endinterface

// File: rtl/datapath_pack_fifo.sv
// rtl/datapath_pack_fifo.sv - width-packing FIFO with paced drain; PACK_FIFO_FWFT_EN selects first-word-fall-through output
module datapath_pack_fifo #(
  parameter int IN_W   = 128,
  parameter int PACK   = 2,
  parameter int OUT_W  = 192,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10,
  parameter int RD_DIV = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  datapath_pack_fifo_if.slave  bus,
  output logic [AW:0]          data_count,
  input  logic [AW:0]          thresh_level,
  output logic                 threshold,
  output logic                 full,
  output logic                 empty,
  input  logic                 flush,
  input  logic                 clr_err,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int BW     = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PW     = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;
  localparam int ASM_W  = IN_W * (PACK - 1);
  localparam int LAST_W = OUT_W - ASM_W;

  localparam logic [BW-1:0] BCNT_LAST = BW'(PACK - 1);
  localparam logic [PW-1:0] PC_LAST   = PW'(RD_DIV - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [OUT_W-1:0]      mem [DEPTH];
  logic [AW:0]           wptr;
  logic [AW:0]           rptr;
  logic [BW-1:0]         bcnt;
  logic [PW-1:0]         pc;
  logic [ASM_W-1:0]      asm_q;
  logic [OUT_W-1:0]      rd_q;
  logic [IN_W*PACK-1:0]  beats;
  logic [OUT_W-1:0]      entry;
  logic                  in_ready;
  logic                  tick;
  logic                  accept;
  logic                  commit;
  logic                  pop;

  assign data_count = wptr - rptr;
  assign full       = (data_count == DEPTH_CNT);
  assign empty      = (data_count == '0);
  assign threshold  = (data_count >= thresh_level);

  // Only a fresh entry is refused when full; a started one always finishes.
  assign in_ready   = !full || (bcnt != '0);
  assign tick       = (pc == PC_LAST);

  // Earlier beats shift up so beat 0 lands in the MSBs; the last beat keeps only its low bits.
  assign beats      = {asm_q, bus.data_in};
  assign entry      = {asm_q, bus.data_in[LAST_W-1:0]};

  assign accept     = bus.wr && in_ready && !flush;
  assign commit     = accept && (bcnt == BCNT_LAST);
  assign pop        = bus.rd && tick && !empty && !flush;

  assign bus.in_ready  = in_ready;
  assign bus.rd_strobe = pop;

`ifdef PACK_FIFO_FWFT_EN
  assign bus.data_out = empty ? rd_q : mem[rptr[AW-1:0]];
`else
  assign bus.data_out = rd_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      mem[wptr[AW-1:0]] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      bcnt      <= '0;
      pc        <= '0;
      asm_q     <= '0;
      rd_q      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pc <= tick ? '0 : pc + 1'b1;

      // A same-cycle set beats the clear so no event is lost.
      if (bus.wr && !in_ready) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end

      if (bus.rd && tick && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end

      if (flush) begin
        wptr <= '0;
        rptr <= '0;
        bcnt <= '0;
      end else begin
        if (accept) begin
          asm_q <= beats[ASM_W-1:0];
          bcnt  <= (bcnt == BCNT_LAST) ? '0 : bcnt + 1'b1;
        end
        if (commit) begin
          wptr <= wptr + 1'b1;
        end
        if (pop) begin
          rd_q <= mem[rptr[AW-1:0]];
          rptr <= rptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_datapath_pack_fifo.sv
// tb/tb_datapath_pack_fifo.sv - directed self-checking bench for datapath_pack_fifo
module tb_datapath_pack_fifo;

  localparam int IN_W   = 128;
  localparam int PACK   = 2;
  localparam int OUT_W  = 192;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int RD_DIV = 4;

  logic          clk;
  logic          rst;
  logic [AW:0]   data_count;
  logic [AW:0]   thresh_level;
  logic          threshold;
  logic          full;
  logic          empty;
  logic          flush;
  logic          clr_err;
  logic          overflow;
  logic          underflow;

  int            n_assert;
  int            n_fail;
  int            tb_pc;
  logic [191:0]  q[$];
  logic [191:0]  rv;

  datapath_pack_fifo_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  datapath_pack_fifo #(
    .IN_W(IN_W), .PACK(PACK), .OUT_W(OUT_W),
    .DEPTH(DEPTH), .AW(AW), .RD_DIV(RD_DIV)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .data_count(data_count),
    .thresh_level(thresh_level),
    .threshold(threshold),
    .full(full),
    .empty(empty),
    .flush(flush),
    .clr_err(clr_err),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected pace phase: first tick RD_DIV-1 cycles after reset, then every RD_DIV.
  always @(posedge clk) begin
    if (rst) tb_pc <= 0;
    else     tb_pc <= (tb_pc == RD_DIV - 1) ? 0 : tb_pc + 1;
  end

  function automatic logic [127:0] b0(int i);
    return {64'hA000_0000_0000_0000 + 64'(i), 64'h5555_0000_0000_0000 + 64'(i)};
  endfunction

  function automatic logic [127:0] b1(int i);
    return {64'hFFFF_FFFF_FFFF_FFFF, 64'hC000_0000_0000_0000 + 64'(i)};
  endfunction

  function automatic logic [191:0] ent(int i);
    return {64'hA000_0000_0000_0000 + 64'(i), 64'h5555_0000_0000_0000 + 64'(i),
            64'hC000_0000_0000_0000 + 64'(i)};
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_entry(input int i);
    bus.wr      = 1'b1;
    bus.data_in = b0(i);
    step();
    bus.data_in = b1(i);
    step();
    bus.wr      = 1'b0;
    q.push_back(ent(i));
  endtask

  task automatic do_read(input string tag, output logic [191:0] val);
    logic got;
    got    = 1'b0;
    bus.rd = 1'b1;
    for (int i = 0; i < 2 * RD_DIV && !got; i++) begin
      #1;
      if (bus.rd_strobe) begin
        chk({tag, "_on_tick"}, 192'(tb_pc == RD_DIV - 1), 192'd1);
        got = 1'b1;
      end
      step();
    end
    bus.rd = 1'b0;
    chk({tag, "_strobe_seen"}, 192'(got), 192'd1);
    val = bus.data_out;
  endtask

  initial begin
    logic [127:0] a_beat;
    logic [127:0] b_beat;
    int           strobes;
    int           pops;
    int           writes;
    int           next_idx;
    bit           phase;
    bit           prev_strobe;

    n_assert     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.wr       = 1'b0;
    bus.rd       = 1'b0;
    bus.data_in  = '0;
    flush        = 1'b0;
    clr_err      = 1'b0;
    thresh_level = 5'd5;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_count",     192'(data_count),    192'd0);
    chk("rst_empty",     192'(empty),         192'd1);
    chk("rst_full",      192'(full),          192'd0);
    chk("rst_threshold", 192'(threshold),     192'd0);
    chk("rst_overflow",  192'(overflow),      192'd0);
    chk("rst_underflow", 192'(underflow),     192'd0);
    chk("rst_strobe",    192'(bus.rd_strobe), 192'd0);
    chk("rst_in_ready",  192'(bus.in_ready),  192'd1);
    chk("rst_data_out",  192'(bus.data_out),  192'd0);
    rst = 1'b0;
    step();

    // Two-beat pack, last beat truncated to its low 64 bits.
    a_beat      = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    b_beat      = 128'h1111_2222_3333_4444_DEAD_BEEF_CAFE_F00D;
    bus.wr      = 1'b1;
    bus.data_in = a_beat;
    step();
    chk("t1_partial_count", 192'(data_count), 192'd0);
    bus.data_in = b_beat;
    step();
    bus.wr = 1'b0;
    chk("t1_commit_count", 192'(data_count), 192'd1);
    chk("t1_not_empty",    192'(empty),      192'd0);
    do_read("t1_read", rv);
    chk("t1_data_out", rv, {a_beat, 64'hDEAD_BEEF_CAFE_F00D});
    chk("t1_count_after", 192'(data_count), 192'd0);
    chk("t1_empty_after", 192'(empty),      192'd1);

    // Threshold crossing at 5 committed entries.
    for (int i = 0; i < 5; i++) begin
      write_entry(i);
      if (i == 3) chk("th_below", 192'(threshold), 192'd0);
    end
    chk("th_count5", 192'(data_count), 192'd5);
    chk("th_at5",    192'(threshold),  192'd1);
    do_read("th_read", rv);
    chk("th_data", rv, q.pop_front());
    chk("th_after_read", 192'(threshold), 192'd0);

    // Fill to DEPTH, then one rejected beat.
    for (int i = 5; i < 17; i++) write_entry(i);
    chk("full_count",    192'(data_count),   192'd16);
    chk("full_flag",     192'(full),         192'd1);
    bus.wr      = 1'b1;
    bus.data_in = 128'hBAD;
    #1;
    chk("full_in_ready", 192'(bus.in_ready), 192'd0);
    step();
    bus.wr = 1'b0;
    chk("ovf_set",        192'(overflow),   192'd1);
    chk("ovf_count_hold", 192'(data_count), 192'd16);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("ovf_cleared", 192'(overflow), 192'd0);

    // Stream 40 entries through a full FIFO; pointers wrap, order must hold.
    pops        = 0;
    writes      = 0;
    next_idx    = 17;
    phase       = 1'b0;
    prev_strobe = 1'b0;
    for (int c = 0; c < 600 && (pops < 40 || writes < 40); c++) begin
      if (prev_strobe) begin
        chk("stream_data", bus.data_out, q.pop_front());
        chk("stream_count_band", 192'(data_count == 5'd15 || data_count == 5'd16), 192'd1);
        pops++;
      end
      bus.rd = (pops < 40);
      if (writes < 40 && bus.in_ready) begin
        bus.wr      = 1'b1;
        bus.data_in = phase ? b1(next_idx) : b0(next_idx);
      end else begin
        bus.wr = 1'b0;
      end
      #1;
      prev_strobe = bus.rd_strobe;
      step();
      if (bus.wr) begin
        if (phase) begin
          q.push_back(ent(next_idx));
          next_idx++;
          writes++;
        end
        phase = ~phase;
      end
    end
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    chk("stream_pops",     192'(pops),       192'd40);
    chk("stream_writes",   192'(writes),     192'd40);
    chk("stream_count",    192'(data_count), 192'd16);
    chk("stream_no_ovf",   192'(overflow),   192'd0);

    // Flush drops stored entries and a half-built one.
    flush = 1'b1;
    step();
    flush = 1'b0;
    q.delete();
    chk("flush_count", 192'(data_count), 192'd0);
    chk("flush_empty", 192'(empty),      192'd1);
    bus.wr      = 1'b1;
    bus.data_in = 128'h7777_7777_7777_7777_7777_7777_7777_7777;
    step();
    bus.wr = 1'b0;
    flush  = 1'b1;
    step();
    flush  = 1'b0;
    bus.wr      = 1'b1;
    bus.data_in = b0(90);
    step();
    chk("flush_bcnt_zero", 192'(data_count), 192'd0);
    bus.data_in = b1(90);
    step();
    bus.wr = 1'b0;
    chk("flush_new_entry", 192'(data_count), 192'd1);
    do_read("flush_read", rv);
    chk("flush_data", rv, ent(90));

    // Reads on an empty FIFO only raise underflow.
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("udf_clear_start", 192'(underflow), 192'd0);
    strobes = 0;
    bus.rd  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.rd_strobe) strobes++;
      step();
    end
    chk("udf_no_strobe", 192'(strobes),   192'd0);
    chk("udf_set",       192'(underflow), 192'd1);
    for (int i = 0; i < RD_DIV && tb_pc != RD_DIV - 1; i++) step();
    chk("udf_found_tick", 192'(tb_pc), 192'(RD_DIV - 1));
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("udf_set_wins", 192'(underflow), 192'd1);
    bus.rd  = 1'b0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("udf_cleared", 192'(underflow), 192'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
